// File: rtl/aes_output_interface_pkg.sv
// ---------------------------------------------------------------------------
// aes_output_interface_pkg
// Shared definitions for the AES result output path: host command codes,
// output-buffer state encodings, stream source select and datapath widths.
// The command codes and state encodings are the same ones the AES input
// interface uses. Keep the two blocks in step when editing.
// ---------------------------------------------------------------------------
package aes_output_interface_pkg;

    typedef enum logic [1:0] {
        C_ID = 2'b00,   // idle / pause
        C_RC = 2'b01,   // read ciphertext
        C_RK = 2'b10,   // read key
        C_CL = 2'b11    // clear
    } cmd_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        FULL   = 2'b01,
        STREAM = 2'b10
    } state_t;

    typedef enum logic {
        SRC_CT  = 1'b0,
        SRC_KEY = 1'b1
    } src_t;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CNT_W-1:0] LAST_BYTE = 4'd15;

endpackage

// File: rtl/aes_byte_select.sv
// ---------------------------------------------------------------------------
// aes_byte_select
// Picks byte idx out of a 128-bit block, MSB-first: idx 0 is bits [127:120],
// idx 15 is bits [7:0].
//
// Ports
//   data_buf  in  128  block to stream
//   idx       in  4    byte index
//   byte_out  out 8    selected byte
// ---------------------------------------------------------------------------
module aes_byte_select
    import aes_output_interface_pkg::*;
(
    input  logic [DATA_W-1:0] data_buf,
    input  logic [CNT_W-1:0]  idx,
    output logic [BYTE_W-1:0] byte_out
);

    // 127 - 8*idx == (15 - idx)*8 + 7 == {~idx, 3'b111}
    assign byte_out = data_buf[{~idx, 3'b111} -: BYTE_W];

endmodule

// File: rtl/aes_output_interface.sv
// ---------------------------------------------------------------------------
// aes_output_interface
// Captures the AES engine result on the rising edge of engine_done and
// streams it to the host one byte per cycle, MSB-first, under command
// control.
//
// Optional feature macro: AES_OUT_KEY_READBACK_EN
//   defined   : key buffer present, C_RK streams the key
//   undefined : no key buffer, key_in unused, C_RK acts like C_ID
//
// Ports
//   clk          in  1    clock, rising edge
//   rst_         in  1    asynchronous reset, active low
//   cmd          in  2    C_ID / C_RC / C_RK / C_CL
//   ct_in        in  128  ciphertext, valid while engine_done is high
//   key_in       in  128  key, valid while engine_done is high
//   engine_done  in  1    engine result-ready level
//   dout         out 8    streamed byte
//   dout_valid   out 1    dout carries a byte this cycle
//   out_ready    out 1    a captured result is buffered
//   read_done    out 1    pulse with the 16th byte of a stream
//   overrun      out 1    sticky: a result arrived mid-stream and was dropped
//
// State  | meaning
// -------+---------------------------------------------------------------
// EMPTY  | nothing buffered; read commands ignored
// FULL   | result buffered, no stream in progress
// STREAM | stream in progress; cnt is the index of the next byte
//
// A read command seen in FULL emits byte 0 on the same edge that enters
// STREAM, so holding a read command for 16 cycles yields all 16 bytes with
// one cycle of latency.
// ---------------------------------------------------------------------------
module aes_output_interface
    import aes_output_interface_pkg::*;
(
    input  logic                clk,
    input  logic                rst_,
    input  logic [1:0]          cmd,
    input  logic [DATA_W-1:0]   ct_in,
    input  logic [DATA_W-1:0]   key_in,
    input  logic                engine_done,
    output logic [BYTE_W-1:0]   dout,
    output logic                dout_valid,
    output logic                out_ready,
    output logic                read_done,
    output logic                overrun
);

    state_t              state;
    src_t                src;
    logic [CNT_W-1:0]    cnt;
    logic                done_q;
    logic [DATA_W-1:0]   ct_buf;

    cmd_t                cmd_e;
    logic                capture;
    logic                rd_ct;
    logic                rd_key;
    logic                rd_any;
    src_t                rd_src;
    logic                emit;
    logic [CNT_W-1:0]    emit_cnt;
    logic [DATA_W-1:0]   sel_buf;
    logic [BYTE_W-1:0]   sel_byte;

    assign cmd_e   = cmd_t'(cmd);
    assign capture = engine_done & ~done_q;
    assign rd_ct   = (cmd_e == C_RC);

`ifdef AES_OUT_KEY_READBACK_EN
    logic [DATA_W-1:0]   key_buf;

    assign rd_key  = (cmd_e == C_RK);
    assign sel_buf = (rd_src == SRC_KEY) ? key_buf : ct_buf;
`else
    logic                unused_key_in;

    assign unused_key_in = ^key_in;
    assign rd_key  = 1'b0;
    assign sel_buf = ct_buf;
`endif

    assign rd_any = rd_ct | rd_key;
    assign rd_src = rd_key ? SRC_KEY : SRC_CT;

    // Decide whether this edge emits a byte and which index it is. A read
    // of the other source while streaming restarts at byte 0. A capture in
    // FULL takes precedence over starting a stream, so a stream never starts
    // from a buffer that is being overwritten on the same edge.
    always_comb begin
        emit     = 1'b0;
        emit_cnt = '0;
        if (cmd_e != C_CL) begin
            case (state)
                FULL: begin
                    emit = rd_any & ~capture;
                end
                STREAM: begin
                    emit = rd_any;
                    if (rd_src == src) begin
                        emit_cnt = cnt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    aes_byte_select u_byte_select (
        .data_buf (sel_buf),
        .idx      (emit_cnt),
        .byte_out (sel_byte)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= EMPTY;
            src        <= SRC_CT;
            cnt        <= '0;
            done_q     <= 1'b0;
            ct_buf     <= '0;
`ifdef AES_OUT_KEY_READBACK_EN
            key_buf    <= '0;
`endif
            dout       <= '0;
            dout_valid <= 1'b0;
            out_ready  <= 1'b0;
            read_done  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            done_q     <= engine_done;
            dout_valid <= 1'b0;
            read_done  <= 1'b0;

            if (emit) begin
                dout       <= sel_byte;
                dout_valid <= 1'b1;
            end

            if (cmd_e == C_CL) begin
                state     <= EMPTY;
                src       <= SRC_CT;
                cnt       <= '0;
                ct_buf    <= '0;
`ifdef AES_OUT_KEY_READBACK_EN
                key_buf   <= '0;
`endif
                out_ready <= 1'b0;
                overrun   <= 1'b0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (capture) begin
                            ct_buf    <= ct_in;
`ifdef AES_OUT_KEY_READBACK_EN
                            key_buf   <= key_in;
`endif
                            out_ready <= 1'b1;
                            state     <= FULL;
                        end
                    end

                    FULL: begin
                        if (capture) begin
                            ct_buf  <= ct_in;
`ifdef AES_OUT_KEY_READBACK_EN
                            key_buf <= key_in;
`endif
                        end else if (rd_any) begin
                            src   <= rd_src;
                            cnt   <= emit_cnt + 4'd1;
                            state <= STREAM;
                        end
                    end

                    STREAM: begin
                        // Results arriving mid-stream are dropped so the
                        // bytes already sent stay consistent.
                        if (capture) begin
                            overrun <= 1'b1;
                        end
                        if (rd_any) begin
                            src <= rd_src;
                            if (emit_cnt == LAST_BYTE) begin
                                read_done <= 1'b1;
                                cnt       <= '0;
                                state     <= FULL;
                            end else begin
                                cnt <= emit_cnt + 4'd1;
                            end
                        end
                    end

                    default: begin
                        state <= EMPTY;
                    end
                endcase
            end
        end
    end

endmodule
